// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for IMEM; holds the core in reset until the image is written.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module imem_loader #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              ILoad,
    output logic [AWIDTH-1:0] IAddr,
    output logic [IWIDTH-1:0] instW,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;
    localparam state_t S_FINAL = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        idx_q, idx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [IWIDTH-1:0]  asm_q, asm_d;
    logic [AWIDTH-1:0]  iaddr_q, iaddr_d;
    logic [IWIDTH-1:0]  instw_q, instw_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               iload_q, done_q, err_q, cpu_rst_q;
    logic               accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
`endif

    assign accept = byte_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        iaddr_d = iaddr_q;
        instw_d = instw_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_HDR0: begin
                if (accept) begin
                    cnt_d[7:0] = byte_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    cnt_d[15:8] = byte_data;
                    if (cnt_d == 16'd0) begin
                        state_d = S_FINAL;
                    end else if (cnt_d > DEPTH16) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Little-endian assembly: byte n lands in bits [8n+7:8n].
                    asm_d[{bcnt_q, 3'b000} +: 8] = byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ byte_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        iaddr_d = AWIDTH'(idx_q) << 2;
                        instw_d = asm_d;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (idx_d == cnt_q) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decodes are taken from the next state so the registered flags line up with the state.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            S_HDR0, S_HDR1, S_DATA: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WRITE: busy_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            default: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            iaddr_q   <= '0;
            instw_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            iload_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            iaddr_q   <= iaddr_d;
            instw_q   <= instw_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            iload_q   <= (state_d == S_WRITE);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
            cpu_rst_q <= (state_d != S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign ILoad      = iload_q;
    assign IAddr      = iaddr_q;
    assign instW      = instw_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader with an image-level model of expected IMEM writes.
module tb_imem_loader;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, ILoad, cpu_rst, busy, done, err;
    logic [31:0] IAddr, instW;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] got_data_q[$];
    logic        prev_iload = 1'b0;
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_loader #(.IWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .ILoad(ILoad), .IAddr(IAddr), .instW(instW),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next word the model derived from the byte stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (ILoad) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_iload: got IAddr %h instW %h expected no write", IAddr, instW);
                end else begin
                    check("iload_addr", IAddr, exp_addr_q.pop_front());
                    check("iload_data", instW, exp_data_q.pop_front());
                    got_data_q.push_back(instW);
                end
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                check("iload_single_cycle", 32'(prev_iload), 32'd0);
            end
            check("cpu_rst_tracks_done", 32'(cpu_rst), 32'(!done));
        end
        prev_iload = rst ? 1'b0 : ILoad;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h got byte_ready=%b expected 1", b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] im[$], input int gap, input bit bad_csum);
        int         count, exp_lat, n;
        bit         exp_ok;
        logic [7:0] x;
        logic [7:0] s[$];
        s = im;
        count = int'({im[1], im[0]});
        x = 8'h00;
        got_data_q.delete();
        exp_ok  = (count <= DEPTH) && !bad_csum;
        exp_lat = 0;
        if (count <= DEPTH) begin
            for (int w = 0; w < count; w++) begin
                exp_addr_q.push_back(32'(w * 4));
                exp_data_q.push_back({im[2+4*w+3], im[2+4*w+2], im[2+4*w+1], im[2+4*w]});
                for (int k = 0; k < 4; k++) x = x ^ im[2+4*w+k];
            end
            if (count > 0) exp_lat = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(bad_csum ? (x ^ 8'h5A) : x);
            exp_lat = 0;
`endif
        end
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        check("err_cleared", 32'(err), 32'd0);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gap > 0 && i != s.size() - 1) repeat (gap) @(negedge clk);
        end
        n = 0;
        while (!done && !err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("final_latency", 32'(n), 32'(exp_lat));
        check("done", 32'(done), 32'(exp_ok));
        check("err", 32'(err), 32'(!exp_ok));
        check("cpu_rst_end", 32'(cpu_rst), 32'(!exp_ok));
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(byte_ready), 32'd0);
        check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_iload", 32'(ILoad), 32'd0);
        check("rst_iaddr", IAddr, 32'd0);
        check("rst_instw", instW, 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Bytes offered in IDLE are refused.
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
        load(img, 0, 1'b0);
        check("pin_word0", got_data_q[0], 32'h00100513);
        check("pin_word1", got_data_q[1], 32'h00A585B3);
        check("done_ready", 32'(byte_ready), 32'd0);

        load(img, 1, 1'b0);
        check("bp_pin_word0", got_data_q[0], 32'h00100513);
        check("bp_pin_word1", got_data_q[1], 32'h00A585B3);

        img = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hFF, 8'h00, 8'hFF, 8'h00};
        load(img, 3, 1'b0);
        check("pin_word2", got_data_q[2], 32'h00FF00FF);

        img = '{8'h00, 8'h00};
        load(img, 0, 1'b0);

        img = '{8'h01, 8'h01};
        load(img, 0, 1'b0);
        check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00};
        load(img, 0, 1'b1);
        check("csum_bad_done", 32'(done), 32'd0);
        img = '{8'h01, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00};
        load(img, 0, 1'b0);
        check("csum_pin_word", got_data_q[0], 32'h0000005A);
`endif

        // Reset after two data bytes of a two-word image.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
        load(img, 0, 1'b0);
        check("reload_pin_word0", got_data_q[0], 32'h00100513);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
